cache_traffic_checker: RTL and testbench
========================================

Name: cache_traffic_checker

Overview:
- Synthesizable, self-checking traffic generator and checker that drives the CPU-side port of generic_cache.
- Issues LFSR-random or sequential reads/writes with byte enables and tracks expected contents in an internal shadow RAM. Reports errors and latency statistics.
- Sits in place of the CPU in cache soak benches and on-FPGA cache bring-up.
- Supports wide data, partial byte enables and a bounded run length.

Parameters:
ADDR_WIDTH, 32, CPU byte-address width
DATA_WIDTH, 32, CPU data width; multiple of 32
WIN_AW, 10, log2 of window depth in words; window is 2**WIN_AW words; max 20
BASE_ADDR, 32'h0, byte address of window start; aligned to window size
RD_THRESH, 128, read if LFSR[7:0] < RD_THRESH (128 = 50% reads)
SEED, 32'h1, LFSR seed; must be non-zero

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a run when idle
stop  in  1  level; ends the run at the next op boundary
mode  in  1  0 = random, 1 = sequential
num_tests  in  32  ops after init; 0 = run until stop
cpu_addr  out  ADDR_WIDTH  request byte address (word aligned)
cpu_rd  out  1  read request
cpu_wr  out  1  write request
cpu_wr_be  out  DATA_WIDTH/8  write byte enables
cpu_wr_data  out  DATA_WIDTH  write data
cpu_rd_data  in  DATA_WIDTH  read data, valid in the accept cycle
cpu_rd_valid  in  1  unused; reserved
cpu_waitrequest  in  1  request stalled while high
busy  out  1  run in progress
done  out  1  run complete; held until next start
ntests, rdtests, wrtests  out  32 each  ops completed (total/read/write)
err_count  out  16  read mismatches, saturating
first_err_addr  out  ADDR_WIDTH  address of first mismatch
first_err_exp, first_err_got  out  DATA_WIDTH each  expected/observed data at first mismatch
max_latency  out  16  worst accept latency in cycles, saturating

Behaviour:
- Reset: all outputs 0. LFSR = SEED. State IDLE. Takes effect immediately, mid-request included; the request is dropped.
- Handshake:
  - Request is accepted at the posedge where cpu_rd or cpu_wr is high and cpu_waitrequest is low.
  - Address, data, be and rd/wr are held stable until acceptance.
  - cpu_rd and cpu_wr are never both high.
  - Read data is sampled at acceptance.
- Latency: cycles from request assertion to acceptance, inclusive (minimum 1).
- FSM:
  - IDLE: start -> INIT, clearing all counters and error captures and setting busy=1, done=0. Start while busy is ignored.
  - INIT: writes word i = 0..2**WIN_AW-1, addr BASE_ADDR+4*i×(DATA_WIDTH/32) word stride, data = i replicated per 32-bit lane, be all ones. Shadow is written identically. INIT ops are not counted in ntests. After the last word -> GEN.
  - GEN: one idle cycle (cpu_rd=cpu_wr=0). If stop, or num_tests!=0 and ntests==num_tests, go to DONE. Otherwise step the LFSR, form the op, issue the shadow RAM read, then go to REQ.
  - REQ: hold the request until accepted, then update counters/shadow/check and go to GEN.
  - DONE: busy=0, done=1; start -> INIT.
- LFSR: 32-bit Galois, polynomial 0x80200003, advanced once per op.
- Random op from new value L:
  - read = L[7:0] < RD_THRESH.
  - index = L[WIN_AW+7:8].
  - be = L[31:28] replicated to width; all-zero be is forced to all ones.
  - data = per 32-bit lane, L XOR lane number XOR ntests.
- Sequential op:
  - write to index k, then read of index k, with k incrementing and wrapping at 2**WIN_AW.
  - data as in random mode; be all ones.
- Writes: the shadow updates only enabled bytes, at acceptance.
- Reads:
  - Compare against shadow; mismatch increments err_count.
  - The first mismatch only captures addr/exp/got.
  - A read to an index written in the immediately preceding op sees the updated shadow (write-first forwarding).
- Counters: 32-bit wrap. err_count and max_latency saturate.
- stop during REQ: the outstanding request completes first.

Decomposition:
- Package cache_tg_pkg: state enum (IDLE, INIT, GEN, REQ, DONE), mode constants, LFSR_POLY, function lfsr_next.
- Sub-module tg_shadow_ram: 2**WIN_AW × DATA_WIDTH, synchronous read, byte-enabled write, write-first on same address.

Test Plan:
- Reset mid-REQ with cpu_waitrequest high -> next cycle cpu_rd=cpu_wr=0, busy=0, done=0, all counters 0.
- WIN_AW=4, zero-wait slave, start -> 16 writes with be=4'hF, cpu_addr 0x0..0x3C, data 0..15, one idle cycle between each; ntests stays 0.
- mode=1, num_tests=8, slave holds waitrequest 3 cycles per request -> ntests=8, rdtests=4, wrtests=4, err_count=0, max_latency=4, done=1.
- mode=0, num_tests=1000, ideal byte-enable memory -> err_count=0; no cpu_wr with be=0; rdtests+wrtests=1000.
- Slave flips bit 0 on the read of 0x20 -> err_count=1, first_err_addr=0x20, first_err_got=first_err_exp^1.
- stop asserted during a 10-cycle stall -> request held until accepted, then GEN, then DONE; ntests includes that op.

Source files
------------

// File: rtl/cache_tg_pkg.sv
// Shared types and helpers for the cache traffic checker: FSM states,
// mode encodings and the op-sequencing LFSR.
package cache_tg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        GEN,
        REQ,
        DONE
    } state_t;

    localparam logic MODE_RANDOM = 1'b0;
    localparam logic MODE_SEQ    = 1'b1;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Right-shifting Galois form: bit 0 feeds back through the tap mask.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/cache_traffic_checker_if.sv
// CPU-side cache port: the checker is the master, the cache is the slave.
interface cache_traffic_checker_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   cpu_addr;
    logic                    cpu_rd;
    logic                    cpu_wr;
    logic [DATA_WIDTH/8-1:0] cpu_wr_be;
    logic [DATA_WIDTH-1:0]   cpu_wr_data;
    logic [DATA_WIDTH-1:0]   cpu_rd_data;
    logic                    cpu_rd_valid;
    logic                    cpu_waitrequest;

    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_wr_be, cpu_wr_data,
        input  cpu_rd_data, cpu_rd_valid, cpu_waitrequest
    );

    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_wr_be, cpu_wr_data,
        output cpu_rd_data, cpu_rd_valid, cpu_waitrequest
    );
endinterface

// File: rtl/tg_shadow_ram.sv
// Shadow copy of the tested window: synchronous read, byte-enabled write,
// write-first when both ports hit the same word in one cycle.
module tg_shadow_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 10
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [AW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**AW];

    // NOTE: the array has no reset so it maps onto block RAM; INIT fills it before any read.
    always_ff @(posedge clock) begin
        for (int b = 0; b < NB; b++) begin
            if (we && wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
        if (re) begin
            for (int b = 0; b < NB; b++) begin
                rdata[b*8 +: 8] <= (we && wbe[b] && waddr == raddr) ? wdata[b*8 +: 8]
                                                                    : mem[raddr][b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/cache_traffic_checker.sv
// Self-checking traffic generator for the CPU port of a cache: fills a window,
// then issues random or sequential ops and checks reads against a shadow RAM.
module cache_traffic_checker
    import cache_tg_pkg::*;
#(
    parameter int              ADDR_WIDTH = 32,
    parameter int              DATA_WIDTH = 32,
    parameter int              WIN_AW     = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int              RD_THRESH  = 128,
    parameter logic [31:0]     SEED       = 32'h1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [31:0]           num_tests,
    cache_traffic_checker_if.master cpu,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           ntests,
    output logic [31:0]           rdtests,
    output logic [31:0]           wrtests,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got,
    output logic [15:0]           max_latency
);
    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int LANES   = DATA_WIDTH / 32;
    localparam int BYTE_SH = $clog2(BE_W);

    state_t                state, state_nxt;
    logic [31:0]           lfsr, lfsr_nxt;
    logic                  init_gap;
    logic [WIN_AW-1:0]     init_idx, seq_idx, op_idx;
    logic                  seq_rd;
    logic                  op_rd;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [BE_W-1:0]       op_be;
    logic [DATA_WIDTH-1:0] op_data;
    logic [15:0]           lat;
    logic [DATA_WIDTH-1:0] shadow_q;

    logic                  gen_rd;
    logic [WIN_AW-1:0]     gen_idx;
    logic [BE_W-1:0]       gen_be;
    logic [DATA_WIDTH-1:0] gen_data;
    logic                  stop_now, accept;
    logic                  unused_rd_valid;

    assign unused_rd_valid = cpu.cpu_rd_valid;
    assign stop_now = stop || (num_tests != 32'd0 && ntests == num_tests);
    assign accept   = (cpu.cpu_rd || cpu.cpu_wr) && !cpu.cpu_waitrequest;
    assign busy     = (state == INIT) || (state == GEN) || (state == REQ);
    assign done     = (state == DONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lfsr_nxt = lfsr_next(lfsr);
        gen_data = '0;
        for (int j = 0; j < LANES; j++) gen_data[j*32 +: 32] = lfsr_nxt ^ 32'(j) ^ ntests;
        if (mode == MODE_SEQ) begin
            gen_rd  = seq_rd;
            gen_idx = seq_idx;
            gen_be  = '1;
        end else begin
            gen_rd  = 32'(lfsr_nxt[7:0]) < 32'(RD_THRESH);
            gen_idx = lfsr_nxt[WIN_AW+7:8];
            gen_be  = {LANES{lfsr_nxt[31:28]}};
            if (gen_be == '0) gen_be = '1;
        end
    end

    always_comb begin
        cpu.cpu_rd      = 1'b0;
        cpu.cpu_wr      = 1'b0;
        cpu.cpu_addr    = '0;
        cpu.cpu_wr_be   = '0;
        cpu.cpu_wr_data = '0;
        if (state == INIT && !init_gap) begin
            cpu.cpu_wr      = 1'b1;
            cpu.cpu_addr    = BASE_ADDR + (ADDR_WIDTH'(init_idx) << BYTE_SH);
            cpu.cpu_wr_be   = '1;
            cpu.cpu_wr_data = {LANES{32'(init_idx)}};
        end else if (state == REQ) begin
            cpu.cpu_rd      = op_rd;
            cpu.cpu_wr      = !op_rd;
            cpu.cpu_addr    = op_addr;
            cpu.cpu_wr_be   = op_be;
            cpu.cpu_wr_data = op_data;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = INIT;
            INIT:       if (accept && (&init_idx)) state_nxt = GEN;
            GEN:        state_nxt = stop_now ? DONE : REQ;
            REQ:        if (accept) state_nxt = GEN;
            default:    state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            lfsr           <= SEED;
            init_gap       <= 1'b0;
            init_idx       <= '0;
            seq_idx        <= '0;
            seq_rd         <= 1'b0;
            op_rd          <= 1'b0;
            op_idx         <= '0;
            op_addr        <= '0;
            op_be          <= '0;
            op_data        <= '0;
            lat            <= '0;
            ntests         <= '0;
            rdtests        <= '0;
            wrtests        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            max_latency    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE, DONE: if (start) begin
                    init_gap       <= 1'b0;
                    init_idx       <= '0;
                    seq_idx        <= '0;
                    seq_rd         <= 1'b0;
                    ntests         <= '0;
                    rdtests        <= '0;
                    wrtests        <= '0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    first_err_exp  <= '0;
                    first_err_got  <= '0;
                    max_latency    <= '0;
                end
                INIT: begin
                    if (init_gap) begin
                        init_gap <= 1'b0;
                    end else if (accept) begin
                        init_gap <= 1'b1;
                        init_idx <= init_idx + WIN_AW'(1);
                    end
                end
                GEN: if (!stop_now) begin
                    lfsr    <= lfsr_nxt;
                    op_rd   <= gen_rd;
                    op_idx  <= gen_idx;
                    op_addr <= BASE_ADDR + (ADDR_WIDTH'(gen_idx) << BYTE_SH);
                    op_be   <= gen_be;
                    op_data <= gen_data;
                    lat     <= 16'd1;
                    if (mode == MODE_SEQ) begin
                        seq_rd <= !seq_rd;
                        if (seq_rd) seq_idx <= seq_idx + WIN_AW'(1);
                    end
                end
                REQ: begin
                    if (accept) begin
                        ntests <= ntests + 32'd1;
                        if (max_latency < lat) max_latency <= lat;
                        if (op_rd) begin
                            rdtests <= rdtests + 32'd1;
                            if (cpu.cpu_rd_data != shadow_q) begin
                                if (err_count != '1) err_count <= err_count + 16'd1;
                                if (err_count == '0) begin
                                    first_err_addr <= op_addr;
                                    first_err_exp  <= shadow_q;
                                    first_err_got  <= cpu.cpu_rd_data;
                                end
                            end
                        end else begin
                            wrtests <= wrtests + 32'd1;
                        end
                    end else if (lat != '1) begin
                        lat <= lat + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow is read in GEN so its word is ready throughout the following REQ.
    tg_shadow_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (WIN_AW)
    ) u_shadow (
        .clock (clock),
        .we    (accept && cpu.cpu_wr),
        .waddr ((state == INIT) ? init_idx : op_idx),
        .wbe   (cpu.cpu_wr_be),
        .wdata (cpu.cpu_wr_data),
        .re    (state == GEN && !stop_now),
        .raddr (gen_idx),
        .rdata (shadow_q)
    );
endmodule

// File: tb/tb_cache_traffic_checker.sv
// Directed bench: a bench-side slave memory answers the checker, and every
// expected op is queued when a run is started and popped as the request appears.
`timescale 1ns/1ps
module tb_cache_traffic_checker;
    localparam int WORDS = 16;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } op_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] num_tests = 32'd0;
    logic        busy, done;
    logic [31:0] ntests, rdtests, wrtests;
    logic [15:0] err_count, max_latency;
    logic [31:0] first_err_addr, first_err_exp, first_err_got;

    cache_traffic_checker_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) cpu ();

    cache_traffic_checker #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .WIN_AW     (4),
        .BASE_ADDR  (32'h0),
        .RD_THRESH  (128),
        .SEED       (32'h1)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .mode           (mode),
        .num_tests      (num_tests),
        .cpu            (cpu),
        .busy           (busy),
        .done           (done),
        .ntests         (ntests),
        .rdtests        (rdtests),
        .wrtests        (wrtests),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_exp  (first_err_exp),
        .first_err_got  (first_err_got),
        .max_latency    (max_latency)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    op_t         sb[$];
    logic [31:0] mem [WORDS];
    logic [31:0] lfsr_m = 32'h1;
    int          ops_acc, test_ops, max_lat_m, rd_m, wr_m, zero_be_wr;
    int          init_stall = 0, test_stall = 0, stop_wait = -1, hang_after = -1;
    bit          rand_stall = 0, flip_en = 0;
    logic [31:0] flip_addr = 32'h0, flip_exp = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    task automatic start_run(input logic m, input int n, input int pushes);
        mode = m; num_tests = 32'(n);
        ops_acc = 0; test_ops = 0; max_lat_m = 0; rd_m = 0; wr_m = 0; zero_be_wr = 0;
        for (int i = 0; i < WORDS; i++) sb.push_back('{1'b0, 32'(i * 4), 4'hF, 32'(i)});
        for (int k = 0; k < pushes; k++) begin
            op_t o;
            lfsr_m = lfsr_step(lfsr_m);
            if (m) begin
                o.rd = k[0]; o.addr = 32'(((k / 2) % WORDS) * 4); o.be = 4'hF;
            end else begin
                o.rd   = (lfsr_m[7:0] < 8'd128);
                o.addr = {26'd0, lfsr_m[11:8], 2'b00};
                o.be   = (lfsr_m[31:28] == 4'h0) ? 4'hF : lfsr_m[31:28];
            end
            o.data = lfsr_m ^ 32'(k);
            if (o.rd) rd_m++; else wr_m++;
            sb.push_back(o);
        end
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    // Acts as the cache slave until done rises, the hang point is reached, or the budget runs out.
    task automatic serve(input int budget);
        op_t         cur;
        logic [69:0] snap;
        bit          in_req = 0, gap = 0, is_test = 0, finished = 0;
        int          waits = 0, lat = 0, since_acc = 0, idx;
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clock);
            since_acc++;
            if (gap) begin
                check("idle_after_accept", 64'({cpu.cpu_rd, cpu.cpu_wr}), 64'd0);
                gap = 0;
            end
            if (done) begin
                check("accept_to_done_cycles", 64'(since_acc), 64'd2);
                finished = 1;
            end else if (cpu.cpu_rd || cpu.cpu_wr) begin
                if (!in_req) begin
                    in_req = 1; lat = 0; is_test = (ops_acc >= WORDS);
                    snap = {cpu.cpu_rd, cpu.cpu_wr, cpu.cpu_addr, cpu.cpu_wr_be, cpu.cpu_wr_data};
                    check("scoreboard_has_op", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) cur = sb.pop_front();
                    check("op_rd", 64'(cpu.cpu_rd), 64'(cur.rd));
                    check("op_wr", 64'(cpu.cpu_wr), 64'(!cur.rd));
                    check("op_addr", 64'(cpu.cpu_addr), 64'(cur.addr));
                    if (!cur.rd) begin
                        check("op_be", 64'(cpu.cpu_wr_be), 64'(cur.be));
                        check("op_data", 64'(cpu.cpu_wr_data), 64'(cur.data));
                        if (cpu.cpu_wr_be == 4'h0) zero_be_wr++;
                    end
                    if (!is_test) check("ntests_during_init", 64'(ntests), 64'd0);
                    waits = !is_test ? init_stall : (rand_stall ? int'($urandom_range(0, 2)) : test_stall);
                    if (is_test && hang_after >= 0 && test_ops == hang_after) begin
                        cpu.cpu_waitrequest = 1'b1;
                        repeat (3) begin
                            @(negedge clock);
                            check("hung_req_held", 64'(cpu.cpu_addr), 64'(cur.addr));
                        end
                        return;
                    end
                end else begin
                    check("req_held_stable", 64'(snap === {cpu.cpu_rd, cpu.cpu_wr, cpu.cpu_addr,
                                                           cpu.cpu_wr_be, cpu.cpu_wr_data}), 64'd1);
                end
                lat++;
                if (waits > 0) begin
                    cpu.cpu_waitrequest = 1'b1;
                    waits--;
                    if (is_test && stop_wait >= 0 && waits == stop_wait) stop = 1'b1;
                end else begin
                    cpu.cpu_waitrequest = 1'b0;
                    in_req = 0; gap = 1; since_acc = 0; ops_acc++;
                    idx = int'(cur.addr[5:2]);
                    if (cur.rd) begin
                        if (flip_en && cur.addr == flip_addr) begin
                            flip_exp = mem[idx];
                            cpu.cpu_rd_data = mem[idx] ^ 32'h1;
                        end else begin
                            cpu.cpu_rd_data = mem[idx];
                        end
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (cur.be[b]) mem[idx][b*8 +: 8] = cur.data[b*8 +: 8];
                    end
                    if (is_test) begin
                        test_ops++;
                        if (lat > max_lat_m) max_lat_m = lat;
                    end
                end
            end else begin
                cpu.cpu_waitrequest = 1'b0;
            end
        end
        check("run_reached_done", 64'(finished), 64'd1);
    endtask

    task automatic end_checks(input int n, input int exp_err);
        check("ntests", 64'(ntests), 64'(n));
        check("rdtests", 64'(rdtests), 64'(rd_m));
        check("wrtests", 64'(wrtests), 64'(wr_m));
        check("err_count", 64'(err_count), 64'(exp_err));
        check("max_latency", 64'(max_latency), 64'(max_lat_m));
        check("done_high", 64'({done, busy}), 64'b10);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        cpu.cpu_waitrequest = 1'b0;
        cpu.cpu_rd_data     = 32'h0;
        cpu.cpu_rd_valid    = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_busy_done", 64'({busy, done}), 64'd0);
        check("reset_rd_wr", 64'({cpu.cpu_rd, cpu.cpu_wr}), 64'd0);
        check("reset_counters", 64'({ntests, err_count, max_latency}), 64'd0);
        reset_n = 1'b1;

        // Sequential, 3-cycle stall per test op: latency 4.
        init_stall = 0; test_stall = 3;
        start_run(1'b1, 8, 8);
        serve(400);
        end_checks(8, 0);
        check("seq_split", 64'({rdtests, wrtests}), {32'd4, 32'd4});

        // Sequential with one corrupted read at 0x20.
        test_stall = 0; flip_en = 1; flip_addr = 32'h20;
        start_run(1'b1, 20, 20);
        serve(400);
        end_checks(20, 1);
        check("first_err_addr", 64'(first_err_addr), 64'h20);
        check("first_err_exp", 64'(first_err_exp), 64'(flip_exp));
        check("first_err_got", 64'(first_err_got), 64'(flip_exp ^ 32'h1));
        flip_en = 0;

        // Random traffic with random stalls against an ideal byte-enable memory.
        rand_stall = 1;
        start_run(1'b0, 1000, 1000);
        serve(6000);
        end_checks(1000, 0);
        check("rd_plus_wr", 64'(rdtests + wrtests), 64'd1000);
        check("no_zero_be_writes", 64'(zero_be_wr), 64'd0);
        rand_stall = 0;

        // Stop raised mid-way through a 10-cycle stall: the op still completes.
        test_stall = 10; stop_wait = 5;
        start_run(1'b0, 0, 1);
        serve(400);
        end_checks(1, 0);
        check("stop_latency", 64'(max_latency), 64'd11);
        stop = 1'b0; stop_wait = -1; test_stall = 0;

        // Reset while a request is stalled.
        hang_after = 3;
        start_run(1'b1, 0, 4);
        serve(400);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_mid_req_rd_wr", 64'({cpu.cpu_rd, cpu.cpu_wr}), 64'd0);
        check("rst_mid_req_busy_done", 64'({busy, done}), 64'd0);
        check("rst_mid_req_counts", 64'({ntests, rdtests}), 64'd0);
        check("rst_mid_req_wr_err", 64'({wrtests, err_count, max_latency}), 64'd0);
        check("rst_mid_req_first_err", 64'(first_err_addr), 64'd0);
        cpu.cpu_waitrequest = 1'b0;
        hang_after = -1;
        lfsr_m = 32'h1;
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;

        // After reset the LFSR restarts from SEED.
        start_run(1'b0, 5, 5);
        serve(200);
        end_checks(5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
